vdcmul_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational 32-bit Vedic (quadrant-split) multiplier.
- Splits each operand into high and low halves, forms four half-width partial products, then sums them over fixed register stages.
- Carries a valid/ready handshake and a user tag alongside each product.
- Sits between operand-issue logic and the result-writeback path of the 64b pipeline multiplier datapath.

---
 rtl/vdcmul_pipe.sv | 141 ++++++++++++++
 tb/tb_vdcmul_pipe.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdcmul_pipe.sv
// rtl/vdcmul_pipe.sv - three-stage quadrant-split multiplier with valid/ready and tag; VDCMUL_SIGNED_EN adds sgn
module vdcmul_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    input  logic [TAG_W-1:0]   in_tag,
`ifdef VDCMUL_SIGNED_EN
    input  logic               sgn,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] prod,
    output logic [TAG_W-1:0]   out_tag,
    output logic               busy
);
    localparam int H  = WIDTH / 2;
    localparam int PW = 2 * H;
    localparam int MW = PW + 2;
    localparam int OW = 2 * WIDTH;

    logic             w_adv;
    logic [WIDTH-1:0] w_xm;
    logic [WIDTH-1:0] w_ym;
    logic             w_neg;
    logic [H-1:0]     w_xl;
    logic [H-1:0]     w_xh;
    logic [H-1:0]     w_yl;
    logic [H-1:0]     w_yh;
    logic [PW-1:0]    w_pp1;
    logic [PW-1:0]    w_pp2;
    logic [PW-1:0]    w_pp3;
    logic [PW-1:0]    w_pp4;
    logic [MW-1:0]    w_mid;
    logic [PW-1:0]    w_top;
    logic [OW-1:0]    w_mag;
    logic [OW-1:0]    w_res;

    logic             r1_valid;
    logic [TAG_W-1:0] r1_tag;
    logic             r1_neg;
    logic [PW-1:0]    r1_pp1;
    logic [PW-1:0]    r1_pp2;
    logic [PW-1:0]    r1_pp3;
    logic [PW-1:0]    r1_pp4;

    logic             r2_valid;
    logic [TAG_W-1:0] r2_tag;
    logic             r2_neg;
    logic [MW-1:0]    r2_mid;
    logic [H-1:0]     r2_lo;
    logic [PW-1:0]    r2_pp4;

    logic             r3_valid;
    logic [OW-1:0]    r3_prod;
    logic [TAG_W-1:0] r3_tag;

    assign w_adv    = !r3_valid || out_ready;
    assign in_ready = w_adv;

`ifdef VDCMUL_SIGNED_EN
    logic w_xneg;
    logic w_yneg;
    // The most negative operand negates to itself, which is its correct unsigned magnitude.
    assign w_xneg = sgn & x[WIDTH-1];
    assign w_yneg = sgn & y[WIDTH-1];
    assign w_xm   = w_xneg ? (~x + WIDTH'(1)) : x;
    assign w_ym   = w_yneg ? (~y + WIDTH'(1)) : y;
    assign w_neg  = w_xneg ^ w_yneg;
`else
    assign w_xm  = x;
    assign w_ym  = y;
    assign w_neg = 1'b0;
`endif

    assign w_xl  = w_xm[H-1:0];
    assign w_xh  = w_xm[WIDTH-1:H];
    assign w_yl  = w_ym[H-1:0];
    assign w_yh  = w_ym[WIDTH-1:H];

    assign w_pp1 = PW'(w_xl) * PW'(w_yl);
    assign w_pp2 = PW'(w_xl) * PW'(w_yh);
    assign w_pp3 = PW'(w_xh) * PW'(w_yl);
    assign w_pp4 = PW'(w_xh) * PW'(w_yh);

    assign w_mid = MW'(r1_pp2) + MW'(r1_pp3) + MW'(r1_pp1[PW-1:H]);

    // Final carry into the top quadrant cannot overflow: the full product fits in 2*WIDTH bits.
    assign w_top = r2_pp4 + PW'(r2_mid[MW-1:H]);
    assign w_mag = {w_top, r2_mid[H-1:0], r2_lo};
    assign w_res = r2_neg ? (~w_mag + OW'(1)) : w_mag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_valid <= 1'b0;
            r1_tag   <= '0;
            r1_neg   <= 1'b0;
            r1_pp1   <= '0;
            r1_pp2   <= '0;
            r1_pp3   <= '0;
            r1_pp4   <= '0;
            r2_valid <= 1'b0;
            r2_tag   <= '0;
            r2_neg   <= 1'b0;
            r2_mid   <= '0;
            r2_lo    <= '0;
            r2_pp4   <= '0;
            r3_valid <= 1'b0;
            r3_prod  <= '0;
            r3_tag   <= '0;
        end else if (w_adv) begin
            r1_valid <= in_valid;
            r1_tag   <= in_tag;
            r1_neg   <= w_neg;
            r1_pp1   <= w_pp1;
            r1_pp2   <= w_pp2;
            r1_pp3   <= w_pp3;
            r1_pp4   <= w_pp4;
            r2_valid <= r1_valid;
            r2_tag   <= r1_tag;
            r2_neg   <= r1_neg;
            r2_mid   <= w_mid;
            r2_lo    <= r1_pp1[H-1:0];
            r2_pp4   <= r1_pp4;
            r3_valid <= r2_valid;
            r3_prod  <= w_res;
            r3_tag   <= r2_tag;
        end
    end

    assign out_valid = r3_valid;
    assign prod      = r3_prod;
    assign out_tag   = r3_tag;
    assign busy      = r1_valid | r2_valid | r3_valid;

endmodule

// File: tb/tb_vdcmul_pipe.sv
// tb/tb_vdcmul_pipe.sv - randomized self-checking bench for vdcmul_pipe (WIDTH=32 and WIDTH=8 instances)
module tb_vdcmul_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] x = '0;
    logic [31:0] y = '0;
    logic [3:0]  in_tag = '0;
    logic        in_ready;
    logic        out_valid;
    logic        busy;
    logic [63:0] prod;
    logic [3:0]  out_tag;

    logic        in_valid8 = 1'b0;
    logic        out_ready8 = 1'b0;
    logic [7:0]  x8 = '0;
    logic [7:0]  y8 = '0;
    logic [3:0]  tag8 = '0;
    logic        in_ready8;
    logic        out_valid8;
    logic        busy8;
    logic [15:0] p8;
    logic [3:0]  out_tag8;
`ifdef VDCMUL_SIGNED_EN
    logic        sgn = 1'b0;
    logic        sgn8 = 1'b0;
`endif

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    vdcmul_pipe #(.WIDTH(32), .TAG_W(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .in_tag(in_tag),
`ifdef VDCMUL_SIGNED_EN
        .sgn(sgn),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .prod(prod),
        .out_tag(out_tag), .busy(busy)
    );

    vdcmul_pipe #(.WIDTH(8), .TAG_W(4)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .x(x8), .y(y8), .in_tag(tag8),
`ifdef VDCMUL_SIGNED_EN
        .sgn(sgn8),
`endif
        .out_valid(out_valid8), .out_ready(out_ready8), .prod(p8),
        .out_tag(out_tag8), .busy(busy8)
    );

    function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input logic s);
        int sa;
        int sb;
        sa = s ? int'($signed(a)) : int'(a);
        sb = s ? int'($signed(b)) : int'(b);
        return 16'(sa * sb);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%0h exp=0", out_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0h exp=0", busy); else n_pass++;
        n_checks++; if (prod !== 64'h0) $display("FAIL reset_prod got=%0h exp=0", prod); else n_pass++;
        n_checks++; if (out_tag !== 4'h0) $display("FAIL reset_out_tag got=%0h exp=0", out_tag); else n_pass++;
        n_checks++; if (out_valid8 !== 1'b0) $display("FAIL reset_out_valid8 got=%0h exp=0", out_valid8); else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%0h exp=1", in_ready); else n_pass++;
    endtask

    task automatic test_latency();
        logic [31:0] tx [2];
        logic [31:0] ty [2];
        logic [3:0]  tt [2];
        logic [63:0] te [2];
        tx[0] = 32'hFFFF_FFFF; ty[0] = 32'hFFFF_FFFF; tt[0] = 4'd3; te[0] = 64'hFFFF_FFFE_0000_0001;
        tx[1] = 32'h0;         ty[1] = 32'hDEAD_BEEF; tt[1] = 4'd5; te[1] = 64'h0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid = 1'b1; x = tx[k]; y = ty[k]; in_tag = tt[k];
            @(posedge clk);
            #1 in_valid = 1'b0;
            for (int c = 1; c <= 3; c++) begin
                @(negedge clk);
                n_checks++;
                if (out_valid !== (c == 3)) $display("FAIL latency_valid op=%0d cyc=%0d got=%0h exp=%0h", k, c, out_valid, (c == 3));
                else n_pass++;
            end
            n_checks++; if (prod !== te[k]) $display("FAIL latency_prod op=%0d got=%0h exp=%0h", k, prod, te[k]); else n_pass++;
            n_checks++; if (out_tag !== tt[k]) $display("FAIL latency_tag op=%0d got=%0h exp=%0h", k, out_tag, tt[k]); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int got = 0;
        int first = -1;
        int last = -1;
        int not_ready = 0;
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid = (c < 8);
            x = 32'(c + 1); y = 32'h1_0000; in_tag = 4'(c);
            #1;
            if (!in_ready) not_ready++;
            if (out_valid) begin
                n_checks++;
                if (prod !== (64'(got + 1) << 16) || out_tag !== 4'(got))
                    $display("FAIL b2b_result idx=%0d got=%0h/%0h exp=%0h/%0h", got, prod, out_tag, (64'(got + 1) << 16), 4'(got));
                else n_pass++;
                if (first < 0) first = c;
                last = c;
                got++;
            end
        end
        in_valid = 1'b0;
        n_checks++; if (got !== 8) $display("FAIL b2b_count got=%0d exp=8", got); else n_pass++;
        n_checks++; if (last - first !== 7) $display("FAIL b2b_gapless got_span=%0d exp=7", last - first); else n_pass++;
        n_checks++; if (not_ready !== 0) $display("FAIL b2b_in_ready got_stalls=%0d exp=0", not_ready); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [63:0] qp[$];
        logic [3:0]  qt[$];
        logic [63:0] held;
        int drained = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid = 1'b1; x = $urandom; y = $urandom; in_tag = 4'(8 + c);
            #1;
            if (in_valid && in_ready) begin
                qp.push_back(64'(x) * 64'(y));
                qt.push_back(in_tag);
            end
        end
        held = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid = 1'b1; x = $urandom; y = $urandom; in_tag = 4'hF;
            #1;
            if (c == 0) held = prod;
            n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready cyc=%0d got=%0h exp=0", c, in_ready); else n_pass++;
            n_checks++;
            if (out_valid !== 1'b1 || prod !== qp[0] || prod !== held || out_tag !== qt[0])
                $display("FAIL bp_hold cyc=%0d got=%0h/%0h/%0h exp=1/%0h/%0h", c, out_valid, prod, out_tag, qp[0], qt[0]);
            else n_pass++;
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid = 1'b0;
            #1;
            if (out_valid) begin
                n_checks++;
                if (qp.size() == 0) $display("FAIL bp_extra got=%0h exp=none", prod);
                else if (prod !== qp[0] || out_tag !== qt[0])
                    $display("FAIL bp_drain got=%0h/%0h exp=%0h/%0h", prod, out_tag, qp[0], qt[0]);
                else n_pass++;
                if (qp.size() != 0) begin void'(qp.pop_front()); void'(qt.pop_front()); end
                drained++;
            end
        end
        n_checks++; if (drained !== 3) $display("FAIL bp_drain_count got=%0d exp=3", drained); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL bp_busy_after got=%0h exp=0", busy); else n_pass++;
    endtask

    task automatic test_reset_midflight();
        int stale = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid = 1'b1; x = $urandom | 32'h1; y = $urandom | 32'h1; in_tag = 4'(c + 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b1) $display("FAIL rstmid_busy_before got=%0h exp=1", busy); else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rstmid_out_valid got=%0h exp=0", out_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy got=%0h exp=0", busy); else n_pass++;
        n_checks++; if (prod !== 64'h0) $display("FAIL rstmid_prod got=%0h exp=0", prod); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            if (out_valid || busy) stale++;
        end
        n_checks++; if (stale !== 0) $display("FAIL rstmid_stale got=%0d exp=0", stale); else n_pass++;
    endtask

    task automatic test_w8_known();
        @(negedge clk);
        out_ready8 = 1'b1;
        in_valid8 = 1'b1; x8 = 8'hAB; y8 = 8'hCD; tag8 = 4'd9;
`ifdef VDCMUL_SIGNED_EN
        sgn8 = 1'b0;
`endif
        @(posedge clk);
        #1 in_valid8 = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (out_valid8 !== 1'b1 || p8 !== 16'h88EF || out_tag8 !== 4'd9)
            $display("FAIL w8_known got=%0h/%0h/%0h exp=1/88ef/9", out_valid8, p8, out_tag8);
        else n_pass++;
    endtask

    task automatic test_w8_random();
        localparam int N = 4096;
        logic [15:0] qp[$];
        logic [3:0]  qt[$];
        int sent = 0;
        int cyc = 0;
        logic prev_hold = 1'b0;
        logic [15:0] prev_p = '0;
        logic [3:0] prev_t = '0;
        logic s;
        while ((sent < N || qp.size() != 0) && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            out_ready8 = ($urandom_range(0, 3) != 0);
            in_valid8 = (sent < N) && ($urandom_range(0, 7) != 0);
            x8 = (sent % 61 == 0) ? 8'h00 : 8'($urandom);
            y8 = (sent % 37 == 0) ? 8'hFF : 8'($urandom);
            tag8 = 4'(sent);
            s = 1'b0;
`ifdef VDCMUL_SIGNED_EN
            sgn8 = 1'($urandom);
            s = sgn8;
`endif
            #1;
            if (prev_hold) begin
                n_checks++;
                if (p8 !== prev_p || out_tag8 !== prev_t || out_valid8 !== 1'b1)
                    $display("FAIL w8_stable got=%0h/%0h exp=%0h/%0h", p8, out_tag8, prev_p, prev_t);
                else n_pass++;
            end
            if (out_valid8 && out_ready8) begin
                n_checks++;
                if (qp.size() == 0) $display("FAIL w8_extra got=%0h exp=none", p8);
                else if (p8 !== qp[0] || out_tag8 !== qt[0])
                    $display("FAIL w8_result got=%0h/%0h exp=%0h/%0h", p8, out_tag8, qp[0], qt[0]);
                else n_pass++;
                if (qp.size() != 0) begin void'(qp.pop_front()); void'(qt.pop_front()); end
            end
            prev_hold = out_valid8 && !out_ready8;
            prev_p = p8;
            prev_t = out_tag8;
            if (in_valid8 && in_ready8) begin
                qp.push_back(model8(x8, y8, s));
                qt.push_back(tag8);
                sent++;
            end
        end
        in_valid8 = 1'b0;
        n_checks++;
        if (sent !== N || qp.size() !== 0) $display("FAIL w8_complete got_sent=%0d pending=%0d exp=%0d/0", sent, qp.size(), N);
        else n_pass++;
    endtask

`ifdef VDCMUL_SIGNED_EN
    task automatic test_signed();
        logic [31:0] tx [3];
        logic [31:0] ty [3];
        logic        ts [3];
        logic [63:0] te [3];
        tx[0] = 32'hFFFF_FFFF; ty[0] = 32'd5;          ts[0] = 1'b1; te[0] = 64'hFFFF_FFFF_FFFF_FFFB;
        tx[1] = 32'h8000_0000; ty[1] = 32'h8000_0000;  ts[1] = 1'b1; te[1] = 64'h4000_0000_0000_0000;
        tx[2] = 32'hFFFF_FFFF; ty[2] = 32'd5;          ts[2] = 1'b0; te[2] = 64'h0000_0004_FFFF_FFFB;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid = 1'b1; x = tx[k]; y = ty[k]; sgn = ts[k]; in_tag = 4'(k);
            @(posedge clk);
            #1 in_valid = 1'b0;
            repeat (3) @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || prod !== te[k]) $display("FAIL signed op=%0d got=%0h/%0h exp=1/%0h", k, out_valid, prod, te[k]);
            else n_pass++;
        end
        sgn = 1'b0;
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_w8_known();
        test_w8_random();
`ifdef VDCMUL_SIGNED_EN
        test_signed();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
